// File: rtl/decoder_addr_scanner_if.sv
// Scan control and address bundle between the scanner and its driver.
// Shared by decoder_addr_scanner and its bench.
interface decoder_addr_scanner_if #(
  parameter int DIV_W = 16
);
  logic             en;
  logic             dir;
  logic [DIV_W-1:0] div_val;
  logic             load;
  logic [2:0]       load_addr;
  logic [7:0]       skip_mask;
  logic [2:0]       address;
  logic             addr_valid;
  logic             step;
  logic             frame_done;

  modport master (
    output en, dir, div_val,
    output load, load_addr, skip_mask,
    input  address, addr_valid,
    input  step, frame_done
  );

  modport slave (
    input  en, dir, div_val,
    input  load, load_addr, skip_mask,
    output address, addr_valid,
    output step, frame_done
  );
endinterface

// File: rtl/decoder_addr_scanner.sv
// Address sequencer for a 3x8 decoder: dwell divider, skip mask, load.
// Define SCAN_BLANK_EN for a 1-cycle blanking state after each change.
module decoder_addr_scanner #(
  parameter int DIV_W    = 16,
  parameter int NUM_ADDR = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder_addr_scanner_if.slave bus
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef SCAN_BLANK_EN
    BLANK,
`endif
    SCAN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] eff_div;
  logic [2:0]       nxt;
  logic             found;
  logic             wrap;
  logic             tick;
  logic             adv;

  assign eff_div = (bus.div_val == '0) ? ONE
                                       : bus.div_val;

  // nearest unmasked neighbour in scan direction
  always_comb begin
    logic [2:0] cand;
    nxt   = bus.address;
    found = 1'b0;
    cand  = bus.address;
    for (int i = 1; i < NUM_ADDR; i++) begin
      cand = bus.dir ? bus.address - 3'(i)
                     : bus.address + 3'(i);
      if (!found && !bus.skip_mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

  // a hold is a full lap, so it counts as a wrap
  assign wrap = bus.dir ? (nxt >= bus.address)
                        : (nxt <= bus.address);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!bus.en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
`ifdef SCAN_BLANK_EN
        IDLE:  state_nx = bus.load ? BLANK : SCAN;
        SCAN:  state_nx = (adv || bus.load) ? BLANK
                                            : SCAN;
        BLANK: state_nx = SCAN;
`else
        IDLE:  state_nx = SCAN;
        SCAN:  state_nx = SCAN;
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    tick = (state != IDLE) && bus.en &&
           (cnt >= eff_div - ONE);
    adv  = tick && found;
    bus.addr_valid = (state == SCAN) &&
                     !bus.skip_mask[bus.address];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      bus.address    <= '0;
      bus.step       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else if (bus.load) begin
      cnt            <= '0;
      bus.address    <= bus.load_addr;
      bus.step       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.step       <= adv;
      bus.frame_done <= tick && wrap;
      if (adv)
        bus.address <= nxt;
      if (state == IDLE || !bus.en || tick)
        cnt <= '0;
      else
        cnt <= cnt + ONE;
    end
  end
endmodule

// File: tb/tb_decoder_addr_scanner.sv
// Directed bench for decoder_addr_scanner.
// Follows SCAN_BLANK_EN to pick expected addr_valid.
module tb_decoder_addr_scanner;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   seq [6] = '{0, 3, 4, 6, 7, 0};

  decoder_addr_scanner_if #(.DIV_W(16)) bus ();

  decoder_addr_scanner #(.DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic outs(input string tag,
                      input int a, input bit v,
                      input bit s, input bit f);
    check({tag, ".addr"}, 32'(bus.address), 32'(a));
    check({tag, ".valid"}, 32'(bus.addr_valid), 32'(v));
    check({tag, ".step"}, 32'(bus.step), 32'(s));
    check({tag, ".fd"}, 32'(bus.frame_done), 32'(f));
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.dir       = 1'b0;
    bus.div_val   = 16'd4;
    bus.load      = 1'b0;
    bus.load_addr = 3'd0;
    bus.skip_mask = 8'h00;
    cyc(3);
    outs("reset", 0, 0, 0, 0);

    // up scan, dwell 4
    rst    = 1'b0;
    bus.en = 1'b1;
    cyc();
    outs("up.start", 0, 1, 0, 0);
    for (int c = 1; c <= 32; c++) begin
      bit s;
      s = (c % 4 == 0);
      cyc();
      outs("up", (c / 4) % 8, BLANK ? !s : 1'b1,
           s, c == 32);
    end

    // down scan, dwell 1
    bus.dir     = 1'b1;
    bus.div_val = 16'd1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      check("dn.addr", 32'(bus.address), 32'((8 - c) % 8));
      check("dn.step", 32'(bus.step), 32'd1);
      check("dn.fd", 32'(bus.frame_done), 32'(c == 1));
    end

    // skip mask, dwell 2
    bus.skip_mask = 8'b0010_0110;
    bus.dir       = 1'b0;
    bus.div_val   = 16'd2;
    for (int c = 1; c <= 10; c++) begin
      bit s;
      s = (c % 2 == 0);
      cyc();
      outs("skip", seq[c / 2], BLANK ? !s : 1'b1,
           s, c == 10);
    end

    // load colliding with a tick at address 2
    bus.skip_mask = 8'h00;
    bus.div_val   = 16'd4;
    cyc(11);
    check("ld.pre", 32'(bus.address), 32'd2);
    bus.load      = 1'b1;
    bus.load_addr = 3'd5;
    cyc();
    outs("ld.hit", 5, !BLANK, 0, 0);
    bus.load = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      outs("ld.dwell", 5, 1, 0, 0);
    end
    cyc();
    check("ld.next", 32'(bus.address), 32'd6);
    check("ld.step", 32'(bus.step), 32'd1);

    // everything masked
    bus.skip_mask = 8'hFF;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      check("ff.addr", 32'(bus.address), 32'd6);
      check("ff.valid", 32'(bus.addr_valid), 32'd0);
      check("ff.step", 32'(bus.step), 32'd0);
    end

    // disable mid-dwell, re-enable restarts cnt
    cyc();
    bus.en = 1'b0;
    cyc();
    check("idle.valid", 32'(bus.addr_valid), 32'd0);
    bus.skip_mask = 8'h00;
    cyc(2);
    check("idle.addr", 32'(bus.address), 32'd6);
    check("idle.valid2", 32'(bus.addr_valid), 32'd0);
    bus.en = 1'b1;
    cyc();
    check("re.valid", 32'(bus.addr_valid), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      check("re.addr", 32'(bus.address), 32'd6);
      check("re.step", 32'(bus.step), 32'd0);
    end
    cyc();
    check("re.next", 32'(bus.address), 32'd7);
    check("re.step1", 32'(bus.step), 32'd1);

    // div_val 0 acts as 1; reset beats load and en
    rst = 1'b1;
    cyc();
    outs("rst2", 0, 0, 0, 0);
    rst         = 1'b0;
    bus.div_val = 16'd0;
    cyc();
    check("d0.addr0", 32'(bus.address), 32'd0);
    cyc();
    check("d0.addr1", 32'(bus.address), 32'd1);
    check("d0.step", 32'(bus.step), 32'd1);
    check("d0.valid", 32'(bus.addr_valid), 32'(!BLANK));
    rst           = 1'b1;
    bus.load      = 1'b1;
    bus.load_addr = 3'd3;
    cyc();
    outs("rst.mid", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
